// File: rtl/wb_arbiter.sv
// Writeback arbiter: grants one of NUM_SRC result producers per cycle onto the
// registered RF write port / bypass. Optional retire counter via WB_RETIRE_CNT_EN.
module wb_arbiter #(
  parameter int XLEN     = 32,
  parameter int NUM_SRC  = 3,
  parameter int REG_AW   = 5,
  parameter int ARB_MODE = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_SRC-1:0]        src_valid,
  output logic [NUM_SRC-1:0]        src_ready,
  input  logic [NUM_SRC*REG_AW-1:0] src_rd,
  input  logic [NUM_SRC*XLEN-1:0]   src_data,
  input  logic                      flush,
  output logic                      rf_we,
  output logic [REG_AW-1:0]         rf_waddr,
  output logic [XLEN-1:0]           rf_wdata,
  output logic                      wb_retire,
  output logic                      byp_valid,
  output logic [REG_AW-1:0]         byp_rd,
  output logic [XLEN-1:0]           byp_data
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [63:0]               retire_cnt
`endif
);

  localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam bit RR    = (ARB_MODE == 1) && (NUM_SRC > 1);

  logic [NUM_SRC-1:0][REG_AW-1:0] rd_a;
  logic [NUM_SRC-1:0][XLEN-1:0]   data_a;
  logic [PTR_W-1:0]               rr_ptr;
  logic [PTR_W-1:0]               gidx;
  logic                           any_gnt;
  logic [REG_AW-1:0]              g_rd;
  logic [XLEN-1:0]                g_data;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_unpack
    assign rd_a[i]   = src_rd[i*REG_AW +: REG_AW];
    assign data_a[i] = src_data[i*XLEN +: XLEN];
  end

  // Priority search starting at the RR pointer (or 0 in fixed mode), wrapping.
  always_comb begin
    int idx;
    src_ready = '0;
    gidx      = '0;
    any_gnt   = 1'b0;
    idx       = 0;
    if (!flush) begin
      for (int k = 0; k < NUM_SRC; k++) begin
        idx = RR ? int'(rr_ptr) + k : k;
        if (idx >= NUM_SRC) idx = idx - NUM_SRC;
        if (!any_gnt && src_valid[idx]) begin
          src_ready[idx] = 1'b1;
          gidx           = PTR_W'(idx);
          any_gnt        = 1'b1;
        end
      end
    end
  end

  assign g_rd   = rd_a[gidx];
  assign g_data = data_a[gidx];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rf_we     <= 1'b0;
      wb_retire <= 1'b0;
      rf_waddr  <= '0;
      rf_wdata  <= '0;
      rr_ptr    <= '0;
    end else begin
      wb_retire <= any_gnt;
      rf_we     <= any_gnt && (g_rd != '0);
      if (any_gnt) begin
        rf_waddr <= g_rd;
        rf_wdata <= g_data;
      end
      if (RR && any_gnt)
        rr_ptr <= (gidx == PTR_W'(NUM_SRC-1)) ? '0 : gidx + 1'b1;
    end
  end

  assign byp_valid = rf_we;
  assign byp_rd    = rf_waddr;
  assign byp_data  = rf_wdata;

`ifdef WB_RETIRE_CNT_EN
  // Counts retirements as seen on the outputs, so it lags wb_retire by a cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          retire_cnt <= '0;
    else if (wb_retire) retire_cnt <= retire_cnt + 64'd1;
  end
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: one fixed-priority and one round-robin instance
// share stimulus; each step checks the selected instance's grant and next-cycle outputs.
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic [2:0]  src_valid = '0;
  logic [14:0] src_rd;
  logic [95:0] src_data;
  logic [4:0]  ch_rd   [3];
  logic [31:0] ch_data [3];
  logic        use_rr = 1'b0;

  logic [2:0]  fp_ready, rr_ready;
  logic        fp_we, rr_we, fp_ret, rr_ret, fp_bv, rr_bv;
  logic [4:0]  fp_addr, rr_addr, fp_brd, rr_brd;
  logic [31:0] fp_data, rr_data, fp_bd, rr_bd;
  logic [63:0] fp_cnt, rr_cnt;

  logic [2:0]  o_ready;
  logic        o_we, o_ret, o_bv;
  logic [4:0]  o_addr, o_brd;
  logic [31:0] o_data, o_bd;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct packed {
    logic        grant;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      src_rd[i*5 +: 5]    = ch_rd[i];
      src_data[i*32 +: 32] = ch_data[i];
    end
  end

  assign o_ready = use_rr ? rr_ready : fp_ready;
  assign o_we    = use_rr ? rr_we    : fp_we;
  assign o_ret   = use_rr ? rr_ret   : fp_ret;
  assign o_bv    = use_rr ? rr_bv    : fp_bv;
  assign o_addr  = use_rr ? rr_addr  : fp_addr;
  assign o_data  = use_rr ? rr_data  : fp_data;
  assign o_brd   = use_rr ? rr_brd   : fp_brd;
  assign o_bd    = use_rr ? rr_bd    : fp_bd;

  wb_arbiter #(.XLEN(32), .NUM_SRC(3), .REG_AW(5), .ARB_MODE(0)) u_fp (
    .clk(clk), .reset(reset), .src_valid(src_valid), .src_ready(fp_ready),
    .src_rd(src_rd), .src_data(src_data), .flush(flush),
    .rf_we(fp_we), .rf_waddr(fp_addr), .rf_wdata(fp_data), .wb_retire(fp_ret),
    .byp_valid(fp_bv), .byp_rd(fp_brd), .byp_data(fp_bd)
`ifdef WB_RETIRE_CNT_EN
    , .retire_cnt(fp_cnt)
`endif
  );

  wb_arbiter #(.XLEN(32), .NUM_SRC(3), .REG_AW(5), .ARB_MODE(1)) u_rr (
    .clk(clk), .reset(reset), .src_valid(src_valid), .src_ready(rr_ready),
    .src_rd(src_rd), .src_data(src_data), .flush(flush),
    .rf_we(rr_we), .rf_waddr(rr_addr), .rf_wdata(rr_data), .wb_retire(rr_ret),
    .byp_valid(rr_bv), .byp_rd(rr_brd), .byp_data(rr_bd)
`ifdef WB_RETIRE_CNT_EN
    , .retire_cnt(rr_cnt)
`endif
  );

`ifndef WB_RETIRE_CNT_EN
  assign fp_cnt = '0;
  assign rr_cnt = '0;
`endif

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
  endtask

  // One cycle: drive at negedge, check grant, push expectation, compare after edge.
  task automatic step(input logic [2:0] v, input logic fl, input logic [2:0] exp_rdy,
                      input logic rr);
    exp_t e;
    int   g;
    @(negedge clk);
    use_rr    = rr;
    src_valid = v;
    flush     = fl;
    #1;
    chk("src_ready", o_ready, exp_rdy);
    g = -1;
    for (int i = 0; i < 3; i++) if (exp_rdy[i]) g = i;
    e = '0;
    if (g >= 0) begin
      e.grant = 1'b1;
      e.addr  = ch_rd[g];
      e.data  = ch_data[g];
      e.we    = (ch_rd[g] != 5'd0);
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("rf_we", o_we, e.we);
    chk("wb_retire", o_ret, e.grant);
    chk("byp_valid", o_bv, e.we);
    if (e.grant) begin
      chk("rf_waddr", o_addr, e.addr);
      chk("rf_wdata", o_data, e.data);
      chk("byp_rd", o_brd, e.addr);
      chk("byp_data", o_bd, e.data);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    src_valid = '0;
    flush     = 1'b0;
    reset     = 1'b1;
    #1;
    chk("rst_we", o_we, 0);
    chk("rst_retire", o_ret, 0);
    chk("rst_addr", o_addr, 0);
    chk("rst_data", o_data, 0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin ch_rd[i] = '0; ch_data[i] = '0; end
    do_reset();

    // Single transfer, then idle: write lasts one cycle, address/data hold.
    ch_rd[0] = 5'd5; ch_data[0] = 32'hDEADBEEF;
    step(3'b001, 0, 3'b001, 0);
    step(3'b000, 0, 3'b000, 0);
    chk("hold_addr", o_addr, 5);
    chk("hold_data", o_data, 32'hDEADBEEF);

    // Fixed-priority contention, back-to-back.
    ch_rd[0] = 5'd1; ch_data[0] = 32'hA0;
    ch_rd[1] = 5'd2; ch_data[1] = 32'hA1;
    ch_rd[2] = 5'd3; ch_data[2] = 32'hA2;
    step(3'b111, 0, 3'b001, 0);
    step(3'b110, 0, 3'b010, 0);
    step(3'b100, 0, 3'b100, 0);
    step(3'b000, 0, 3'b000, 0);

    // x0 write: retires but no RF write.
    ch_rd[1] = 5'd0; ch_data[1] = 32'h1234;
    step(3'b010, 0, 3'b010, 0);

    // Flush kills the grant; an already-registered write still shows.
    ch_rd[1] = 5'd7; ch_data[1] = 32'h77;
    step(3'b001, 0, 3'b001, 0);
    step(3'b010, 1, 3'b000, 0);
    step(3'b010, 0, 3'b010, 0);
    step(3'b000, 0, 3'b000, 0);

    // Round-robin fairness and pointer wrap.
    use_rr = 1'b1;
    do_reset();
    ch_rd[1] = 5'd2; ch_data[1] = 32'hA1;
    step(3'b111, 0, 3'b001, 1);
    step(3'b111, 0, 3'b010, 1);
    step(3'b111, 0, 3'b100, 1);
    step(3'b111, 0, 3'b001, 1);
    step(3'b111, 0, 3'b010, 1);
    step(3'b111, 0, 3'b100, 1);
    step(3'b111, 1, 3'b000, 1);   // pointer holds at 0 through flush
    step(3'b111, 0, 3'b001, 1);   // ptr -> 1
    step(3'b110, 0, 3'b010, 1);   // ptr -> 2
    step(3'b011, 0, 3'b001, 1);   // ch2 idle, search wraps to ch0
    step(3'b000, 0, 3'b000, 1);

    // Async reset while a write is on the outputs.
    ch_rd[0] = 5'd5; ch_data[0] = 32'hCAFE;
    step(3'b001, 0, 3'b001, 0);
    src_valid = '0;
    #1 reset = 1'b1;
    #1;
    chk("async_we", o_we, 0);
    chk("async_retire", o_ret, 0);
    chk("async_bv", o_bv, 0);
    chk("async_addr", o_addr, 0);
    @(negedge clk);
    reset = 1'b0;
`ifdef WB_RETIRE_CNT_EN
    chk("cnt_rst", fp_cnt, 0);
`endif
    for (int i = 0; i < 4; i++) step(3'b001, 0, 3'b001, 0);
    step(3'b000, 0, 3'b000, 0);
`ifdef WB_RETIRE_CNT_EN
    chk("cnt_4", fp_cnt, 4);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Parametrised writeback stage for the riscv32 core.
- Arbitrates up to NUM_SRC result producers (ALU, load unit, CSR/mul…) onto the single register-file write port through a valid/ready handshake.
- Output is registered; the registered result doubles as the bypass path to decode/execute.
- Successor to the fixed single-source writeback interface: adds channel count, arbitration mode, x0 suppression and flush.

Parameters:
- XLEN, 32, data width of results and register-file write data.
- NUM_SRC, 3, number of producer channels (1..8).
- REG_AW, 5, register address width.
- ARB_MODE, 0, 0 = fixed priority (index 0 highest); 1 = round-robin.

Ports:
- clk  input  1  core clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- src_valid  input  NUM_SRC  per-channel result valid.
- src_ready  output  NUM_SRC  per-channel grant; combinational, one-hot or zero.
- src_rd  input  NUM_SRC*REG_AW  packed destination registers; channel i at [i*REG_AW +: REG_AW].
- src_data  input  NUM_SRC*XLEN  packed result data; channel i at [i*XLEN +: XLEN].
- flush  input  1  pipeline flush; kills the current-cycle grant.
- rf_we  output  1  register-file write enable, registered.
- rf_waddr  output  REG_AW  register-file write address, registered.
- rf_wdata  output  XLEN  register-file write data, registered.
- wb_retire  output  1  one-cycle pulse per accepted result, including rd = 0.
- byp_valid  output  1  bypass valid; equals rf_we.
- byp_rd  output  REG_AW  bypass register; equals rf_waddr.
- byp_data  output  XLEN  bypass data; equals rf_wdata.

Behaviour:
- Reset (async assert, sync deassert by clock): rf_we, wb_retire and byp_valid = 0; rf_waddr and rf_wdata = 0; round-robin pointer = 0. The RR pointer value is the index of the highest-priority channel.
- Handshake:
  - A transfer on channel i occurs in cycle t when src_valid[i] && src_ready[i].
  - At most one src_ready bit is high per cycle.
  - src_ready depends only on src_valid, the RR pointer and flush. It never depends on src_ready.
  - A producer holds valid, rd and data stable until ready.
- Fixed priority (ARB_MODE = 0): grant = lowest-index valid channel.
- Round-robin (ARB_MODE = 1):
  - Search starts at the pointer and wraps modulo NUM_SRC.
  - After a grant to channel g, pointer <= (g+1) mod NUM_SRC. Wrap: g = NUM_SRC-1 gives pointer 0.
  - With no grant, the pointer holds.
- Latency: a transfer in cycle t drives rf_we, rf_waddr, rf_wdata and wb_retire in cycle t+1, for exactly one cycle unless a new transfer follows. Back-to-back transfers give one write per cycle, with no bubble.
- x0 suppression: a transfer with rd = 0 gives rf_we = 0 and byp_valid = 0, but wb_retire = 1. rf_waddr and rf_wdata still update.
- Flush:
  - While flush = 1, src_ready = 0 and the pointer holds.
  - At the next edge, rf_we and wb_retire are cleared.
  - A write already registered in the flush cycle still completes that cycle.
- No valid source: rf_we = 0 and wb_retire = 0 next cycle; address and data hold.
- NUM_SRC = 1: src_ready[0] = src_valid[0] && !flush; ARB_MODE is ignored.
- Reset mid-operation: outputs clear immediately and asynchronously; any in-flight grant is dropped.

Optional Feature:
- Macro: WB_RETIRE_CNT_EN.
- When defined:
  - Adds output port retire_cnt, 64 bits, reset to 0.
  - Increments by 1 on each cycle where wb_retire = 1, i.e. the count reflects retirements visible at the outputs.
  - Wraps from 2^64-1 to 0.
  - Not cleared by flush.
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset, then single transfer: ARB_MODE = 0, src_valid = 3'b001, rd = 5, data = 0xDEADBEEF.
  - src_ready = 3'b001 the same cycle.
  - Next cycle rf_we = 1, rf_waddr = 5, rf_wdata = 0xDEADBEEF, wb_retire = 1.
  - Following cycle rf_we = 0.
- Fixed-priority contention: src_valid = 3'b111 held, each channel holding valid after its grant is dropped.
  - Grants occur in order ch0, ch1, ch2 across 3 consecutive cycles, with no bubble.
  - rf_waddr sequence matches each channel's rd.
- Round-robin fairness: ARB_MODE = 1, all 3 channels continuously valid for 6 cycles.
  - Grant order is 0, 1, 2, 0, 1, 2.
  - Pointer wraps to 0 after grant 2.
- x0 write: transfer with rd = 0, data = 0x1234.
  - Next cycle rf_we = 0, byp_valid = 0, wb_retire = 1.
- Flush: src_valid = 3'b010 with flush = 1 for one cycle.
  - src_ready = 0, no write next cycle.
  - Grant occurs the cycle after flush drops.
- Async reset mid-stream: assert reset between clock edges while rf_we = 1.
  - rf_we = 0 before the next edge.
  - With WB_RETIRE_CNT_EN, retire_cnt = 0, and it counts 4 after 4 subsequent transfers.
